inst_sequencer: RTL and testbench
=================================

# inst_sequencer

Multi-cycle instruction sequencer for the 16-bit FPGA processor. It fetches instructions from the program memory, holds them in an instruction register, and drives the phase enables for the opcode decoder, register file and ALU. Write-back is gated with the decoder's register-write flag. The block sits between the program memory and the decoder/datapath and owns the program counter and the run/step/done handshake.

## Interface
Parameters:
- ADDR_W, 8, program-memory address width
- INST_W, 16, instruction width; opcode = ir[INST_W-1:INST_W-4]

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE
- step_mode  in  1  1 = pause after each write-back
- step  in  1  advance from PAUSE
- prog_len  in  ADDR_W+1  number of instructions to run (0..2^ADDR_W)
- imem_addr  out  ADDR_W  program-memory address (= pc)
- imem_rd  out  1  program-memory read strobe
- imem_data  in  INST_W  instruction; valid one cycle after imem_rd
- ir  out  INST_W  latched instruction to the decoder/datapath
- dec_reg_write  in  1  decoder register-write flag for ir
- rf_rd_en  out  1  register-file read phase
- alu_en  out  1  ALU execute phase
- rf_we  out  1  register-file write strobe
- out_valid  out  1  Read-instruction (opcode 2) result valid
- pc  out  ADDR_W  current program counter
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, WAIT, DECODE, EXEC, WB, PAUSE, DONE.
- IDLE:
  - If start=1 and prog_len≠0: clear pc to 0 and go to FETCH.
  - If start=1 and prog_len=0: go to DONE.
- FETCH: imem_rd=1, imem_addr=pc; go to WAIT.
- WAIT: latch imem_data into ir; go to DECODE.
- DECODE: rf_rd_en=1; go to EXEC.
- EXEC: alu_en=1; go to WB.
- WB:
  - rf_we = dec_reg_write; out_valid = (opcode==2).
  - pc increments.
  - If pc+1 == prog_len: go to DONE.
  - Else if step_mode=1: go to PAUSE.
  - Else: go to FETCH.
- PAUSE: hold all enables low. step=1 goes to FETCH. Clearing step_mode also goes to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- Opcode 0 (nop) runs through every phase. It writes nothing because dec_reg_write=0.
- abort in any non-IDLE state goes to IDLE next cycle with no rf_we. abort takes priority over every other transition, including a WB write (the write in an aborting WB cycle is suppressed).
- start while busy is ignored. start and abort together in IDLE: abort wins, stay in IDLE.
- pc width is ADDR_W. With prog_len = 2^ADDR_W, pc wraps to 0 at the final WB, then DONE.

## Timing
- Reset values: state IDLE, pc 0, ir 0, and all strobes, busy and done at 0.
- Start accepted at edge 0: FETCH in cycle 1, WAIT 2, DECODE 3, EXEC 4, WB 5.
- Without pausing, each instruction takes 5 cycles.
- A run of N instructions ends with WB at cycle 5N, done at cycle 5N+1, and IDLE from 5N+2.
- All outputs are registered-state decodes. Phase strobes are exactly one cycle wide.
- In step mode, FETCH follows the cycle after step is sampled.
- ir holds its value from WAIT+1 through the next WAIT.

## Structure
- Shared package seq_pkg holds:
  - state enum (3 bits)
  - OP_NOP=4'd0, OP_READ=4'd2
  - opcode field slice constants
- Optional sub-module seq_pc: pc register with clear/increment and terminal compare against prog_len.
- The decoder remains a separate instance. The sequencer consumes only dec_reg_write from it.

## Test plan
- Reset mid-run (rst_n low during EXEC) → all outputs 0 and IDLE immediately; a new start runs from pc 0.
- prog_len=3, program {0x1A05, 0x5012, 0x2010}, dec_reg_write={1,1,0}:
  - rf_we at cycles 5 and 10; out_valid at cycle 15
  - done at cycle 16; imem_addr 0,1,2 in FETCH cycles 1,6,11
- prog_len=0 with start → done at cycle 1, imem_rd never asserted.
- step_mode=1, prog_len=2 → PAUSE after the first WB; FETCH of pc=1 only after step; done after the second WB.
- abort asserted in WB of the 2nd instruction → rf_we stays 0 in that cycle, IDLE next cycle, no done pulse.
- prog_len=2^ADDR_W with nop program → 5·2^ADDR_W cycles, pc wraps to 0, done asserted once.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
//   state_e  : sequencer phase encoding (3 bits)
//   OP_*     : opcodes the sequencer itself reacts to
//   OPC_W    : width of the opcode field at the top of the instruction word
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_PAUSE  = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_READ = 4'd2;

  // Opcode occupies ir[INST_W-1 -: OPC_W].
  localparam int OPC_W = 4;

endpackage

// File: rtl/seq_pc.sv
// Program counter for the sequencer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : load 0 (start of a run; wins over inc_i)
//   inc_i         : advance by one (write-back of an instruction)
//   prog_len_i    : run length, one bit wider than pc so 2^ADDR_W fits
//   pc_o          : current program counter
//   last_o        : pc is the final instruction of the run
module seq_pc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [ADDR_W:0]   prog_len_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   pc_next_ext;

  always_comb begin
    pc_d = pc_q;
    if (clr_i)      pc_d = '0;
    else if (inc_i) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  // Compare in ADDR_W+1 bits so a full-memory run terminates even though
  // pc itself wraps to 0 on that final increment.
  assign pc_next_ext = {1'b0, pc_q} + (ADDR_W + 1)'(1);
  assign last_o      = (pc_next_ext == prog_len_i);
  assign pc_o        = pc_q;

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle instruction sequencer: fetch -> wait -> decode -> exec -> wb.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, abort     : run request (IDLE only) / return to IDLE at once
//   step_mode, step  : pause after each write-back, advance from pause
//   prog_len         : instructions to run (0 .. 2^ADDR_W)
//   imem_addr/rd     : program-memory address and read strobe
//   imem_data        : instruction, valid the cycle after imem_rd
//   ir               : latched instruction for decoder/datapath
//   dec_reg_write    : decoder's register-write flag for ir
//   rf_rd_en, alu_en : read and execute phase enables
//   rf_we, out_valid : write-back strobe, read-instruction result valid
//   pc, busy, done   : program counter, non-idle flag, completion pulse
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] ir,
  input  logic              dec_reg_write,
  output logic              rf_rd_en,
  output logic              alu_en,
  output logic              rf_we,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [INST_W-1:0] ir_q;
  logic [OPC_W-1:0]  opcode;
  logic              pc_clr, pc_inc, pc_last;
  logic [ADDR_W-1:0] pc_w;

  seq_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (pc_clr),
    .inc_i      (pc_inc),
    .prog_len_i (prog_len),
    .pc_o       (pc_w),
    .last_o     (pc_last)
  );

  always_comb begin
    state_d = state_q;
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (prog_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            pc_clr  = 1'b1;
          end
        end
      end
      S_FETCH:  state_d = S_WAIT;
      S_WAIT:   state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        pc_inc = 1'b1;
        if (pc_last)        state_d = S_DONE;
        else if (step_mode) state_d = S_PAUSE;
        else                state_d = S_FETCH;
      end
      // Dropping step_mode while paused releases the pause like a step.
      S_PAUSE:  if (step || !step_mode) state_d = S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort overrides every transition, including the pc advance in WB.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pc_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Memory is registered, so the word addressed in FETCH arrives in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ir_q <= '0;
    else if (state_q == S_WAIT) ir_q <= imem_data;
  end

  assign opcode    = ir_q[INST_W-1 -: OPC_W];
  assign ir        = ir_q;
  assign pc        = pc_w;
  assign imem_addr = pc_w;
  assign imem_rd   = (state_q == S_FETCH);
  assign rf_rd_en  = (state_q == S_DECODE);
  assign alu_en    = (state_q == S_EXEC);
  // An aborting write-back cycle must not commit anything.
  assign rf_we     = (state_q == S_WB) && dec_reg_write && !abort;
  assign out_valid = (state_q == S_WB) && (opcode == OP_READ) && !abort;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: each run's expected strobe timeline
// is built from the phase timing rules, and a monitor pops and compares
// every strobe the sequencer presents.
module tb_inst_sequencer;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;
  localparam int MEMSZ  = 1 << ADDR_W;

  typedef enum int {EV_FETCH, EV_DEC, EV_ALU, EV_WE, EV_OV, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       pc;    // -1: not compared
    int       data;  // -1: not compared
    int       rel;   // cycle relative to the start request
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, step_mode, step;
  logic [ADDR_W:0]   prog_len;
  logic [ADDR_W-1:0] imem_addr, pc;
  logic              imem_rd, rf_rd_en, alu_en, rf_we, out_valid, busy, done;
  logic [INST_W-1:0] imem_data = '0;
  logic [INST_W-1:0] ir;
  logic              dec_reg_write;

  logic [INST_W-1:0] mem   [MEMSZ];
  bit                wflag [MEMSZ];
  logic [ADDR_W-1:0] fetch_addr = '0;

  ev_t exp_q[$];
  int  cyc = 0;
  int  t0  = 0;
  int  n_vec = 0;
  int  n_err = 0;

  inst_sequencer #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .step_mode     (step_mode),
    .step          (step),
    .prog_len      (prog_len),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .imem_data     (imem_data),
    .ir            (ir),
    .dec_reg_write (dec_reg_write),
    .rf_rd_en      (rf_rd_en),
    .alu_en        (alu_en),
    .rf_we         (rf_we),
    .out_valid     (out_valid),
    .pc            (pc),
    .busy          (busy),
    .done          (done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered program memory and a decoder stand-in whose write flag
  // belongs to the most recently fetched instruction.
  always @(posedge clk) begin
    if (imem_rd) begin
      imem_data  <= mem[imem_addr];
      fetch_addr <= imem_addr;
    end
  end
  assign dec_reg_write = wflag[fetch_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input ev_kind_e kind, input int act_pc, input int act_data);
    ev_t e;
    int  now;
    now = cyc - t0;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL ev_%s: strobe at cycle %0d pc=%0d, expected none", kind.name(), now, act_pc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (e.pc >= 0 && e.pc != act_pc) ||
          (e.data >= 0 && e.data != act_data) || e.rel != now) begin
        n_err++;
        $display("FAIL ev_%s: got pc=%0d data=%0h cycle=%0d, expected %s pc=%0d data=%0h cycle=%0d",
                 kind.name(), act_pc, act_data, now, e.kind.name(), e.pc, e.data, e.rel);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_rd)   pop_chk(EV_FETCH, int'(imem_addr), -1);
      if (rf_rd_en)  pop_chk(EV_DEC,   int'(pc), int'(ir));
      if (alu_en)    pop_chk(EV_ALU,   int'(pc), -1);
      if (rf_we)     pop_chk(EV_WE,    int'(pc), -1);
      if (out_valid) pop_chk(EV_OV,    int'(pc), -1);
      if (done)      pop_chk(EV_DONE,  int'(pc), -1);
    end
  end

  // Events at or past the cut cycle never happen: an abort still shows
  // that cycle's phase strobes but no write-back, a reset shows nothing.
  task automatic push_ev(input ev_kind_e k, input int p, input int d, input int rel,
                         input int cut, input bit is_rst);
    ev_t e;
    if (cut >= 0) begin
      if (rel > cut) return;
      if (rel == cut && (is_rst || k == EV_WE || k == EV_OV)) return;
    end
    e.kind = k; e.pc = p; e.data = d; e.rel = rel;
    exp_q.push_back(e);
  endtask

  // One run: n instructions from mem/wflag, optional step mode, optional
  // abort at cycle arel or reset at cycle rrel (-1 = none).
  task automatic run(input int n, input bit sm, input int arel, input int rrel);
    int rel_cyc[$];
    bit rel_by_mode[$];
    int t, wb, endr, last, cut, idx, p;
    bit is_rst;
    is_rst = (rrel >= 0);
    cut    = is_rst ? rrel : arel;
    t      = 1;
    wb     = 0;
    for (int k = 0; k < n; k++) begin
      idx = k % MEMSZ;
      push_ev(EV_FETCH, idx, -1, t, cut, is_rst);
      push_ev(EV_DEC, idx, int'(mem[idx]), t + 2, cut, is_rst);
      push_ev(EV_ALU, idx, -1, t + 3, cut, is_rst);
      if (wflag[idx]) push_ev(EV_WE, idx, -1, t + 4, cut, is_rst);
      if (int'(mem[idx]) / 4096 == 2) push_ev(EV_OV, idx, -1, t + 4, cut, is_rst);
      wb = t + 4;
      t  = t + 5;
      if (sm && k != n - 1) begin
        p = $urandom_range(0, 3);
        rel_cyc.push_back(wb + 1 + p);
        rel_by_mode.push_back(1'($urandom_range(0, 1)));
        t = wb + 2 + p;
      end
    end
    endr = (n == 0) ? 1 : wb + 1;
    push_ev(EV_DONE, (n == 0) ? -1 : n % MEMSZ, -1, endr, cut, is_rst);
    last = (cut >= 0 && cut < endr) ? cut : endr;

    @(posedge clk); #1;
    t0        = cyc;
    start     = 1'b1;
    prog_len  = (ADDR_W + 1)'(n);
    step_mode = sm;
    step      = 1'b0;
    abort     = (arel == 0);
    for (int r = 1; r <= last + 2; r++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_c%0d", r), int'(busy), int'(r <= last));
      if (is_rst && r == rrel + 1) rst_n = 1'b1;
      start     = (r <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort     = (r == arel);
      step      = 1'b0;
      step_mode = sm;
      for (int i = 0; i < rel_cyc.size(); i++) begin
        if (rel_cyc[i] == r) begin
          if (rel_by_mode[i]) step_mode = 1'b0;
          else                step = 1'b1;
        end
      end
      if (is_rst && r == rrel) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({imem_rd, rf_rd_en, alu_en, rf_we, out_valid, done}), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_ir", int'(ir), 0);
      end
    end
    start = 1'b0; abort = 1'b0; step = 1'b0;
    chk("pending_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, arel;
    bit sm;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; step = 1'b0; step_mode = 1'b0;
    prog_len = '0;
    for (int k = 0; k < MEMSZ; k++) begin
      mem[k] = '0;
      wflag[k] = 1'b0;
    end
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_strobes", int'({imem_rd, rf_rd_en, alu_en, rf_we, out_valid}), 0);
    chk("reset_pc", int'(pc), 0);
    chk("reset_ir", int'(ir), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed three-instruction program.
    mem[0] = 16'h1A05; mem[1] = 16'h5012; mem[2] = 16'h2010;
    wflag[0] = 1'b1; wflag[1] = 1'b1; wflag[2] = 1'b0;
    run(3, 1'b0, -1, -1);
    // Empty program.
    run(0, 1'b0, -1, -1);
    // Step mode over two instructions.
    run(2, 1'b1, -1, -1);
    // Abort in write-back of the second instruction.
    run(3, 1'b0, 10, -1);
    // Start together with abort in IDLE.
    run(3, 1'b0, 0, -1);
    // Reset during EXEC, then a clean rerun.
    run(3, 1'b0, -1, 4);
    run(3, 1'b0, -1, -1);

    // Full-memory nop program.
    for (int k = 0; k < MEMSZ; k++) begin
      mem[k] = '0;
      wflag[k] = 1'b0;
    end
    run(MEMSZ, 1'b0, -1, -1);

    // Randomized runs.
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < MEMSZ; k++) begin
        mem[k] = INST_W'($urandom);
        if ($urandom_range(0, 2) == 0) mem[k][INST_W-1 -: 4] = 4'd2;
        wflag[k] = 1'($urandom_range(0, 1));
      end
      n    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
      sm   = 1'($urandom_range(0, 1));
      arel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5 * n + 1)) : -1;
      run(n, sm, arel, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
